// File: rtl/sid_player_pkg.sv
// ---------------------------------------------------------------------------
// sid_player_pkg : shared types and widths for the SID register player
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sid_player_pkg;

  localparam int DELAY_W = 16;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DELAY_W-1:0] delay;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/sid_player_fifo.sv
// ---------------------------------------------------------------------------
// sid_player_fifo : synchronous command FIFO with a registered head entry
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sid_player_fifo
  import sid_player_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  cmd_t             push_data,
  input  logic             pop,
  output cmd_t             head,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] w_rd_nxt;

  assign w_rd_nxt = pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      level    <= '0;
      head     <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      level    <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_rd_nxt;
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      // Bypass covers the entry being written into the slot that becomes head.
      if (push && (r_wr_ptr == w_rd_nxt)) head <= push_data;
      else                                head <= r_mem[w_rd_nxt];
    end
  end

endmodule

`default_nettype wire

// File: rtl/sid_reg_player.sv
// ---------------------------------------------------------------------------
// sid_reg_player : timed SID register-write player fed from a command FIFO
// Optional statistics ports enabled by macro SID_REG_PLAYER_STATS_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sid_reg_player
  import sid_player_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ce_1m,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DELAY_W-1:0]            in_delay,
  input  logic [ADDR_W-1:0]             in_addr,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          sid_we,
  output logic [ADDR_W-1:0]             sid_addr,
  output logic [DATA_W-1:0]             sid_data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
`ifdef SID_REG_PLAYER_STATS_EN
  output logic [15:0]                   underrun_cnt,
  output logic [15:0]                   write_cnt,
`endif
  output logic                          busy
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  cmd_t               w_head;
  cmd_t               w_in_cmd;
  logic               w_push;
  logic               w_pop;
  state_t             r_state;
  logic [DELAY_W-1:0] r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;

  assign w_in_cmd = '{delay: in_delay, addr: in_addr, data: in_data};
  assign in_ready = (level != LVL_W'(FIFO_DEPTH));
  assign w_push   = in_valid & in_ready & ~flush;
  assign w_pop    = (r_state == IDLE) & (level != '0) & ~flush;
  assign busy     = (r_state != IDLE) | (level != '0);

  sid_player_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (w_push),
    .push_data (w_in_cmd),
    .pop       (w_pop),
    .head      (w_head),
    .level     (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      sid_we   <= 1'b0;
      sid_addr <= '0;
      sid_data <= '0;
    end else begin
      sid_we <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (level != '0) begin
              r_state <= WAIT;
              r_cnt   <= w_head.delay;
              r_addr  <= w_head.addr;
              r_data  <= w_head.data;
            end
          end
          WAIT: begin
            if (r_cnt == '0)  r_state <= WRITE;
            else if (ce_1m)   r_cnt   <= r_cnt - DELAY_W'(1);
          end
          WRITE: begin
            sid_we   <= 1'b1;
            sid_addr <= r_addr;
            sid_data <= r_data;
            r_state  <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef SID_REG_PLAYER_STATS_EN
  logic r_armed;

  // Underruns only count once playback has produced at least one write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed      <= 1'b0;
      underrun_cnt <= '0;
      write_cnt    <= '0;
    end else if (flush) begin
      r_armed      <= 1'b0;
      underrun_cnt <= '0;
      write_cnt    <= '0;
    end else begin
      if (r_state == WRITE) begin
        r_armed   <= 1'b1;
        write_cnt <= write_cnt + 16'd1;
      end
      if (r_armed && ce_1m && (r_state == IDLE) && (level == '0) &&
          (underrun_cnt != 16'hFFFF))
        underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sid_reg_player.sv
// ---------------------------------------------------------------------------
// tb_sid_reg_player : directed self-checking bench for sid_reg_player
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sid_reg_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_1m;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_delay;
  logic [4:0]  in_addr;
  logic [7:0]  in_data;
  logic        sid_we;
  logic [4:0]  sid_addr;
  logic [7:0]  sid_data;
  logic [4:0]  level;
  logic        busy;
`ifdef SID_REG_PLAYER_STATS_EN
  logic [15:0] underrun_cnt;
  logic [15:0] write_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int b2b      = 0;
  logic prev_we = 1'b0;
  logic [4:0] mon_addr [$];
  logic [7:0] mon_data [$];
  int         mon_cyc  [$];

  sid_reg_player #(.FIFO_DEPTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .ce_1m    (ce_1m),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_delay (in_delay),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .sid_we   (sid_we),
    .sid_addr (sid_addr),
    .sid_data (sid_data),
    .level    (level),
`ifdef SID_REG_PLAYER_STATS_EN
    .underrun_cnt (underrun_cnt),
    .write_cnt    (write_cnt),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sid_we) begin
      mon_addr.push_back(sid_addr);
      mon_data.push_back(sid_data);
      mon_cyc.push_back(cyc);
    end
    if (sid_we && prev_we) b2b++;
    prev_we = sid_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic [4:0] a, input logic [7:0] v);
    logic rdy;
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_delay = d;
    in_addr  = a;
    in_data  = v;
    for (int i = 0; i < 200; i++) begin
      rdy = in_ready;
      step();
      if (rdy) begin
        done = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic ce_pulse();
    ce_1m = 1'b1;
    step();
    ce_1m = 1'b0;
    step();
  endtask

  initial begin
    int base;
    reset = 1'b1; ce_1m = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_delay = '0; in_addr = '0; in_data = '0;
    step(); step();

    // Reset state
    check("rst_we",    {31'd0, sid_we},   32'd0);
    check("rst_addr",  {27'd0, sid_addr}, 32'd0);
    check("rst_data",  {24'd0, sid_data}, 32'd0);
    check("rst_level", {27'd0, level},    32'd0);
    check("rst_busy",  {31'd0, busy},     32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    step();

    // Delay 0: strobe two clocks after the pop edge
    push(16'd0, 5'h04, 8'h41);
    step();
    check("t1_level_after_pop", {27'd0, level}, 32'd0);
    check("t1_busy_wait",       {31'd0, busy},  32'd1);
    step();
    check("t1_we_early",        {31'd0, sid_we}, 32'd0);
    step();
    check("t1_we",   {31'd0, sid_we},   32'd1);
    check("t1_addr", {27'd0, sid_addr}, 32'h04);
    check("t1_data", {24'd0, sid_data}, 32'h41);
    step();
    check("t1_we_off", {31'd0, sid_we}, 32'd0);
    check("t1_busy",   {31'd0, busy},   32'd0);

    // Delay 3 with ce_1m every 16 clk
    base = mon_addr.size();
    push(16'd3, 5'h18, 8'h0F);
    step();
    for (int k = 0; k < 3; k++) begin
      repeat (15) step();
      ce_1m = 1'b1;
      step();
      ce_1m = 1'b0;
    end
    step();
    check("t2_no_early", mon_addr.size() - base, 32'd0);
    check("t2_we_pre",   {31'd0, sid_we}, 32'd0);
    step();
    check("t2_we",   {31'd0, sid_we},   32'd1);
    check("t2_addr", {27'd0, sid_addr}, 32'h18);
    check("t2_data", {24'd0, sid_data}, 32'h0F);
    step(); step();

    // Fill FIFO while stalled, then drain 17 writes in order
    base = mon_addr.size();
    push(16'd5, 5'h1F, 8'hAA);
    step();
    for (int i = 0; i < 16; i++) push(16'd0, 5'(i), 8'(8'h80 + i));
    check("t3_level_full", {27'd0, level},    32'd16);
    check("t3_ready_full", {31'd0, in_ready}, 32'd0);
    repeat (5) ce_pulse();
    for (int i = 0; i < 200; i++) begin
      if (mon_addr.size() >= base + 17) break;
      step();
    end
    check("t3_count", mon_addr.size() - base, 32'd17);
    if (mon_addr.size() >= base + 17) begin
      check("t3_addr0", {27'd0, mon_addr[base]}, 32'h1F);
      check("t3_data0", {24'd0, mon_data[base]}, 32'hAA);
      for (int i = 1; i < 17; i++) begin
        check($sformatf("t3_addr%0d", i), {27'd0, mon_addr[base+i]}, 32'(i - 1));
        check($sformatf("t3_data%0d", i), {24'd0, mon_data[base+i]}, 32'(8'h80 + i - 1));
        check($sformatf("t3_gap%0d", i), mon_cyc[base+i] - mon_cyc[base+i-1], 32'd3);
      end
    end
    step(); step();

    // Flush during a long WAIT with 4 queued; same-cycle push discarded
    push(16'd1000, 5'h01, 8'h11);
    step();
    for (int i = 0; i < 4; i++) push(16'd0, 5'(i + 2), 8'(8'h20 + i));
    check("t4_level_q", {27'd0, level}, 32'd4);
    ce_pulse(); ce_pulse();
    base = mon_addr.size();
    flush = 1'b1; in_valid = 1'b1; in_delay = 16'd0; in_addr = 5'h09; in_data = 8'h99;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t4_level", {27'd0, level}, 32'd0);
    check("t4_busy",  {31'd0, busy},  32'd0);
    repeat (20) ce_pulse();
    check("t4_no_write", mon_addr.size() - base, 32'd0);

    // Reset in a WRITE cycle with another entry pending
    base = mon_addr.size();
    push(16'd0, 5'h07, 8'h77);
    push(16'd0, 5'h08, 8'h88);
    step();
    reset = 1'b1;
    #1;
    check("t5_we",    {31'd0, sid_we},   32'd0);
    check("t5_addr",  {27'd0, sid_addr}, 32'd0);
    check("t5_data",  {24'd0, sid_data}, 32'd0);
    check("t5_level", {27'd0, level},    32'd0);
    check("t5_busy",  {31'd0, busy},     32'd0);
    step(); step();
    reset = 1'b0;
    repeat (10) step();
    check("t5_dropped", mon_addr.size() - base, 32'd0);
    push(16'd0, 5'h0A, 8'h5A);
    step(); step(); step();
    check("t5_we_new",   {31'd0, sid_we},   32'd1);
    check("t5_addr_new", {27'd0, sid_addr}, 32'h0A);
    check("t5_data_new", {24'd0, sid_data}, 32'h5A);
    step(); step();

`ifdef SID_REG_PLAYER_STATS_EN
    flush = 1'b1; step(); flush = 1'b0;
    push(16'd0, 5'h03, 8'h33);
    repeat (4) step();
    repeat (10) ce_pulse();
    check("st_write_cnt",    {16'd0, write_cnt},    32'd1);
    check("st_underrun_cnt", {16'd0, underrun_cnt}, 32'd10);
    flush = 1'b1; step(); flush = 1'b0;
    check("st_write_clr",    {16'd0, write_cnt},    32'd0);
    check("st_underrun_clr", {16'd0, underrun_cnt}, 32'd0);
`endif

    check("no_back_to_back", b2b, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
